// File: rtl/mesi_bus_arbiter.sv
// Snoopy-bus controller for a group of MESI cache controllers.
// Grants one requester at a time round-robin, snoops the others, and fetches from memory on a miss.
module mesi_bus_arbiter #(
    parameter int NUM_CACHE = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*NUM_CACHE-1:0]      bus_req,
    input  logic [ADDR_W*NUM_CACHE-1:0] req_addr,
    input  logic [NUM_CACHE-1:0]        snoop_hit,
    input  logic                        mem_rd_ack,
    output logic [NUM_CACHE-1:0]        grant,
    output logic                        snoop_valid,
    output logic [1:0]                  snoop_req,
    output logic [ADDR_W-1:0]           snoop_addr,
    output logic [NUM_CACHE-1:0]        snoop_src,
    output logic                        mem_rd_req,
    output logic [ADDR_W-1:0]           mem_rd_addr,
    output logic [2*NUM_CACHE-1:0]      bus_rsp,
    output logic                        busy
);

    localparam int PTR_W = (NUM_CACHE > 1) ? $clog2(NUM_CACHE) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SNOOP    = 3'd1;
    localparam logic [2:0] ST_HIT_WAIT = 3'd2;
    localparam logic [2:0] ST_MEM      = 3'd3;
    localparam logic [2:0] ST_RSP      = 3'd4;

    localparam logic [1:0] BUS_NO_REQ          = 2'd0;
    localparam logic [1:0] BUS_INVALIDATE_REQ  = 2'd3;
    localparam logic [1:0] BUS_NO_RSP          = 2'd0;
    localparam logic [1:0] BUS_SNOOP_FOUND_RSP = 2'd1;
    localparam logic [1:0] BUS_FETCH_MEM_RSP   = 2'd2;

    logic [NUM_CACHE-1:0] req_vld;
    logic [1:0]           req_type_arr [NUM_CACHE];
    logic [ADDR_W-1:0]    req_addr_arr [NUM_CACHE];

    logic [2:0]             state_q,       state_d;
    logic [PTR_W-1:0]       rr_ptr_q,      rr_ptr_d;
    logic [PTR_W-1:0]       win_q,         win_d;
    logic [1:0]             type_q,        type_d;
    logic [ADDR_W-1:0]      addr_q,        addr_d;
    logic [1:0]             rsp_q,         rsp_d;
    logic [NUM_CACHE-1:0]   grant_q,       grant_d;
    logic                   snoop_valid_q, snoop_valid_d;
    logic [1:0]             snoop_req_q,   snoop_req_d;
    logic [ADDR_W-1:0]      snoop_addr_q,  snoop_addr_d;
    logic [NUM_CACHE-1:0]   snoop_src_q,   snoop_src_d;
    logic                   mem_rd_req_q,  mem_rd_req_d;
    logic [ADDR_W-1:0]      mem_rd_addr_q, mem_rd_addr_d;
    logic [2*NUM_CACHE-1:0] bus_rsp_q,     bus_rsp_d;
    logic                   busy_q,        busy_d;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] rr_next;
    int               cand;
    logic             hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CACHE; gi++) begin : g_unpack
            assign req_type_arr[gi] = bus_req[2*gi +: 2];
            assign req_addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
            assign req_vld[gi]      = (bus_req[2*gi +: 2] != BUS_NO_REQ);
        end
    endgenerate

    // Rotating priority: first requester at or above rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int j = 0; j < NUM_CACHE; j++) begin
            cand = (int'(rr_ptr_q) + j) % NUM_CACHE;
            if (!win_found && req_vld[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign rr_next = (win_idx == PTR_W'(NUM_CACHE - 1)) ? '0 : win_idx + 1'b1;

    // The originator's own hit bit never counts as a sharer.
    assign hit = |(snoop_hit & ~snoop_src_q);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        type_d   = type_q;
        addr_d   = addr_q;
        rsp_d    = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d  = ST_SNOOP;
                    win_d    = win_idx;
                    type_d   = req_type_arr[win_idx];
                    addr_d   = req_addr_arr[win_idx];
                    rr_ptr_d = rr_next;
                end
            end
            ST_SNOOP: state_d = ST_HIT_WAIT;
            ST_HIT_WAIT: begin
                if (type_q == BUS_INVALIDATE_REQ) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    state_d = ST_RSP;
                    rsp_d   = BUS_SNOOP_FOUND_RSP;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                if (mem_rd_ack) begin
                    state_d = ST_RSP;
                    rsp_d   = BUS_FETCH_MEM_RSP;
                end
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    generate
        for (gi = 0; gi < NUM_CACHE; gi++) begin : g_out
            assign grant_d[gi] = (state_d != ST_IDLE) && (win_d == PTR_W'(gi));
            assign bus_rsp_d[2*gi +: 2] =
                ((state_d == ST_RSP) && (win_q == PTR_W'(gi))) ? rsp_d : BUS_NO_RSP;
        end
    endgenerate

    always_comb begin
        snoop_valid_d = (state_d == ST_SNOOP);
        snoop_req_d   = snoop_req_q;
        snoop_addr_d  = snoop_addr_q;
        snoop_src_d   = snoop_src_q;
        if (state_d == ST_SNOOP) begin
            snoop_req_d  = type_d;
            snoop_addr_d = addr_d;
            snoop_src_d  = grant_d;
        end
        mem_rd_req_d  = (state_d == ST_MEM);
        mem_rd_addr_d = (state_d == ST_MEM) ? addr_q : mem_rd_addr_q;
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            win_q         <= '0;
            type_q        <= '0;
            addr_q        <= '0;
            rsp_q         <= BUS_NO_RSP;
            grant_q       <= '0;
            snoop_valid_q <= 1'b0;
            snoop_req_q   <= '0;
            snoop_addr_q  <= '0;
            snoop_src_q   <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_rd_addr_q <= '0;
            bus_rsp_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            win_q         <= win_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            rsp_q         <= rsp_d;
            grant_q       <= grant_d;
            snoop_valid_q <= snoop_valid_d;
            snoop_req_q   <= snoop_req_d;
            snoop_addr_q  <= snoop_addr_d;
            snoop_src_q   <= snoop_src_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            bus_rsp_q     <= bus_rsp_d;
            busy_q        <= busy_d;
        end
    end

    assign grant       = grant_q;
    assign snoop_valid = snoop_valid_q;
    assign snoop_req   = snoop_req_q;
    assign snoop_addr  = snoop_addr_q;
    assign snoop_src   = snoop_src_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign bus_rsp     = bus_rsp_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter with four caches: reset, hit, miss, masked hit, invalidate, round-robin.
module tb_mesi_bus_arbiter;

    logic         clk;
    logic         rst_n;
    logic [7:0]   bus_req;
    logic [127:0] req_addr;
    logic [3:0]   snoop_hit;
    logic         mem_rd_ack;
    logic [3:0]   grant;
    logic         snoop_valid;
    logic [1:0]   snoop_req;
    logic [31:0]  snoop_addr;
    logic [3:0]   snoop_src;
    logic         mem_rd_req;
    logic [31:0]  mem_rd_addr;
    logic [7:0]   bus_rsp;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    mesi_bus_arbiter #(.NUM_CACHE(4), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_req     (bus_req),
        .req_addr    (req_addr),
        .snoop_hit   (snoop_hit),
        .mem_rd_ack  (mem_rd_ack),
        .grant       (grant),
        .snoop_valid (snoop_valid),
        .snoop_req   (snoop_req),
        .snoop_addr  (snoop_addr),
        .snoop_src   (snoop_src),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .bus_rsp     (bus_rsp),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " grant"},       64'(grant),       64'h0);
        chk({tag, " snoop_valid"}, 64'(snoop_valid), 64'h0);
        chk({tag, " mem_rd_req"},  64'(mem_rd_req),  64'h0);
        chk({tag, " bus_rsp"},     64'(bus_rsp),     64'h0);
        chk({tag, " busy"},        64'(busy),        64'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus_req    = '0;
        req_addr   = '0;
        snoop_hit  = '0;
        mem_rd_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset snoop_req",   64'(snoop_req),   64'h0);
        chk("reset snoop_addr",  64'(snoop_addr),  64'h0);
        chk("reset snoop_src",   64'(snoop_src),   64'h0);
        chk("reset mem_rd_addr", 64'(mem_rd_addr), 64'h0);
        rst_n = 1'b1;
        step();

        // ---- reset in the middle of a memory fetch
        bus_req[3:2]        = 2'd1;
        req_addr[32*1 +: 32] = 32'h1111_0000;
        step();
        chk("rstmem grant", 64'(grant), 64'h2);
        step();
        step();
        chk("rstmem mem_rd_req",  64'(mem_rd_req),  64'h1);
        chk("rstmem mem_rd_addr", 64'(mem_rd_addr), 64'h1111_0000);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rstmem async");
        chk("rstmem async mem_rd_addr", 64'(mem_rd_addr), 64'h0);
        bus_req = '0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        mem_rd_ack = 1'b1;
        step();
        mem_rd_ack = 1'b0;
        chk_idle_outputs("rstmem after");
        step();
        chk("rstmem after2 bus_rsp", 64'(bus_rsp), 64'h0);

        // rr_ptr back at 0: with caches 1 and 2 requesting, cache 1 must win
        bus_req              = 8'h14;
        req_addr[32*2 +: 32] = 32'h2222_0000;
        step();
        chk("rrzero grant first", 64'(grant), 64'h2);
        step();
        snoop_hit = 4'b0001;
        step();
        chk("rrzero rsp1", 64'(bus_rsp), 64'h04);
        bus_req   = 8'h10;
        snoop_hit = 4'b0000;
        step();
        chk("rrzero idle grant", 64'(grant), 64'h0);
        step();
        chk("rrzero grant second", 64'(grant), 64'h4);
        chk("rrzero snoop_addr",   64'(snoop_addr), 64'h2222_0000);
        step();
        snoop_hit = 4'b0001;
        step();
        chk("rrzero rsp2", 64'(bus_rsp), 64'h10);
        bus_req   = '0;
        snoop_hit = '0;
        step();
        chk_idle_outputs("rrzero end");

        // ---- single READ hit from cache 0
        bus_req[1:0]         = 2'd1;
        req_addr[32*0 +: 32] = 32'h0000_0040;
        step();
        chk("hit snoop_valid", 64'(snoop_valid), 64'h1);
        chk("hit snoop_src",   64'(snoop_src),   64'h1);
        chk("hit snoop_req",   64'(snoop_req),   64'h1);
        chk("hit snoop_addr",  64'(snoop_addr),  64'h40);
        chk("hit grant",       64'(grant),       64'h1);
        chk("hit busy",        64'(busy),        64'h1);
        step();
        chk("hit snoop_valid off", 64'(snoop_valid), 64'h0);
        chk("hit c2 mem_rd_req",   64'(mem_rd_req),  64'h0);
        snoop_hit = 4'b0100;
        step();
        chk("hit bus_rsp",    64'(bus_rsp),    64'h01);
        chk("hit mem_rd_req", 64'(mem_rd_req), 64'h0);
        bus_req   = '0;
        snoop_hit = '0;
        step();
        chk_idle_outputs("hit end");

        // ---- READ miss from cache 3, memory answers in the fifth MEM cycle
        bus_req[7:6]         = 2'd1;
        req_addr[32*3 +: 32] = 32'hDEAD_BEC0;
        step();
        chk("miss grant snoop",  64'(grant),      64'h8);
        chk("miss snoop_addr",   64'(snoop_addr), 64'hDEAD_BEC0);
        mem_rd_ack = 1'b1;
        step();
        mem_rd_ack           = 1'b0;
        bus_req              = '0;
        req_addr[32*3 +: 32] = 32'h1234_5678;
        chk("miss hitwait mem_rd_req", 64'(mem_rd_req), 64'h0);
        step();
        chk("miss mem1 mem_rd_req",  64'(mem_rd_req),  64'h1);
        chk("miss mem1 mem_rd_addr", 64'(mem_rd_addr), 64'hDEAD_BEC0);
        chk("miss mem1 grant",       64'(grant),       64'h8);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("miss memN mem_rd_req", 64'(mem_rd_req), 64'h1);
            chk("miss memN grant",      64'(grant),      64'h8);
            chk("miss memN bus_rsp",    64'(bus_rsp),    64'h0);
        end
        mem_rd_ack = 1'b1;
        step();
        mem_rd_ack = 1'b0;
        chk("miss bus_rsp",    64'(bus_rsp),    64'h80);
        chk("miss mem_rd_req", 64'(mem_rd_req), 64'h0);
        chk("miss rsp grant",  64'(grant),      64'h8);
        step();
        chk_idle_outputs("miss end");

        // ---- RWITM where only the requester's own hit bit is set
        bus_req[3:2]         = 2'd2;
        req_addr[32*1 +: 32] = 32'h0000_2000;
        step();
        chk("rwitm snoop_req", 64'(snoop_req), 64'h2);
        chk("rwitm snoop_src", 64'(snoop_src), 64'h2);
        step();
        snoop_hit = 4'b0010;
        step();
        snoop_hit = 4'b0000;
        chk("rwitm mem_rd_req",  64'(mem_rd_req),  64'h1);
        chk("rwitm mem_rd_addr", 64'(mem_rd_addr), 64'h2000);
        chk("rwitm mem bus_rsp", 64'(bus_rsp),     64'h0);
        mem_rd_ack = 1'b1;
        step();
        mem_rd_ack = 1'b0;
        chk("rwitm bus_rsp", 64'(bus_rsp), 64'h08);
        bus_req = '0;
        step();
        chk_idle_outputs("rwitm end");

        // ---- INVALIDATE from cache 2: no response, no memory access
        bus_req[5:4]         = 2'd3;
        req_addr[32*2 +: 32] = 32'h0000_3000;
        step();
        chk("inv snoop_valid", 64'(snoop_valid), 64'h1);
        chk("inv snoop_req",   64'(snoop_req),   64'h3);
        chk("inv snoop_src",   64'(snoop_src),   64'h4);
        bus_req = '0;
        step();
        chk("inv hitwait snoop_valid", 64'(snoop_valid), 64'h0);
        chk("inv hitwait busy",        64'(busy),        64'h1);
        snoop_hit = 4'b1111;
        step();
        snoop_hit = '0;
        chk_idle_outputs("inv end");
        step();
        chk_idle_outputs("inv end2");

        // ---- reset pulse, then all caches request READ continuously with hits forced
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle_outputs("rr reset");
        snoop_hit = 4'b1111;
        bus_req   = 8'h55;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr grant",       64'(grant),     64'(1) << (k % 4));
            chk("rr snoop_src",   64'(snoop_src), 64'(1) << (k % 4));
            step();
            step();
            chk("rr bus_rsp",     64'(bus_rsp),   64'(1) << (2 * (k % 4)));
            chk("rr rsp grant",   64'(grant),     64'(1) << (k % 4));
            bus_req[2*(k%4) +: 2] = 2'd0;
            step();
            chk("rr idle grant",  64'(grant),     64'h0);
            chk("rr idle busy",   64'(busy),      64'h0);
            bus_req[2*(k%4) +: 2] = 2'd1;
        end
        bus_req   = '0;
        snoop_hit = '0;
        step();
        step();
        step();
        step();
        step();
        chk_idle_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mesi_bus_arbiter.md
Name: mesi_bus_arbiter

Overview:
- Shared snoopy-bus controller between NUM_CACHE per-core cache controllers.
- Each cache presents a 2-bit bus request and a line address.
- The arbiter grants one requester round-robin, broadcasts the request to all other caches as a snoop, and collects their hit indications.
- It fetches from memory when no cache holds the line, then returns the 2-bit bus response to the winner only.

Parameters:
- NUM_CACHE, 4, number of attached cache controllers (2..8).
- ADDR_W, 32, line address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bus_req  in  2*NUM_CACHE  per-cache request; slice i = cache i. Encodings from cache_def.v: BUS_NO_REQ=0, BUS_READ_REQ=1, BUS_RWITM_REQ=2, BUS_INVALIDATE_REQ=3
- req_addr  in  ADDR_W*NUM_CACHE  per-cache line address
- snoop_hit  in  NUM_CACHE  per-cache "line present" indication, valid the cycle after snoop_valid
- mem_rd_ack  in  1  memory read complete
- grant  out  NUM_CACHE  one-hot current owner; 0 when idle
- snoop_valid  out  1  snoop broadcast strobe
- snoop_req  out  2  broadcast request type
- snoop_addr  out  ADDR_W  broadcast address
- snoop_src  out  NUM_CACHE  one-hot originator; snooping caches ignore their own bit
- mem_rd_req  out  1  memory read request
- mem_rd_addr  out  ADDR_W  memory read address
- bus_rsp  out  2*NUM_CACHE  per-cache response. BUS_NO_RSP=0, BUS_SNOOP_FOUND_RSP=1, BUS_FETCH_MEM_RSP=2, 3 never driven
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (async, any state):
  - state = IDLE, rr_ptr = 0.
  - grant, snoop_valid, snoop_req, snoop_addr, snoop_src, mem_rd_req, mem_rd_addr, bus_rsp and busy all = 0.
  - A transaction interrupted by reset is dropped; no response is issued.
- Arbitration (IDLE only):
  - Requesters are caches with bus_req != 0.
  - Winner = first requester scanning from rr_ptr upward, mod NUM_CACHE.
  - On grant, latch winner, type and address; rr_ptr <= winner+1, wrapping to 0 after NUM_CACHE-1.
  - No requester: stay in IDLE.
- FSM states: IDLE, SNOOP, HIT_WAIT, MEM, RSP.
  - IDLE -> SNOOP when any request is present.
  - SNOOP: snoop_valid = 1 for exactly one cycle, with snoop_req/addr/src = latched values. Always -> HIT_WAIT.
  - HIT_WAIT: sample hit = |(snoop_hit & ~snoop_src).
    - INVALIDATE -> IDLE; no bus_rsp is driven, because the requester does not wait.
    - READ/RWITM with hit -> RSP, response = SNOOP_FOUND.
    - READ/RWITM without hit -> MEM.
  - MEM: mem_rd_req = 1 and mem_rd_addr = latched addr, held until mem_rd_ack is sampled high.
    - Then -> RSP, response = FETCH_MEM. mem_rd_req drops in the same edge.
  - RSP: the winner's bus_rsp slice = response for exactly one cycle; all other slices = 0. -> IDLE.
- grant = winner one-hot from SNOOP through RSP inclusive; 0 in IDLE.
- Latency from the first cycle bus_req is seen in IDLE:
  - Hit path: bus_rsp valid 3 cycles later.
  - Miss path: bus_rsp valid 3 cycles + memory wait cycles later.
  - Ack in the first MEM cycle gives 4.
- Requester behaviour during a transaction:
  - Changes to the winner's bus_req or req_addr are ignored; latched values are used.
  - The winner drops its request on the response cycle, so it does not re-win the next IDLE arbitration.
  - Pending requests of losers persist and are arbitrated when the FSM returns to IDLE.
- Boundary conditions:
  - mem_rd_ack outside MEM is ignored.
  - snoop_hit outside HIT_WAIT is ignored.
  - The requester's own snoop_hit bit is masked.
  - Back-to-back transactions: IDLE lasts exactly one cycle if requests are pending, giving one transaction per 4 cycles minimum.
- Simultaneous requests from all caches are served in rotating order starting at rr_ptr; no starvation.

Test Plan:
- Reset mid-MEM: cache 1 READ miss, assert rst_n=0 while mem_rd_req=1 -> all outputs 0 immediately (async); after release, bus_rsp stays 0 and rr_ptr = 0.
- Single READ hit: cache 0 req=1, addr=0x40, cache 2 snoop_hit=1 in HIT_WAIT -> snoop_valid at cycle 1 with snoop_src=0001, bus_rsp[1:0]=1 at cycle 3, mem_rd_req never high.
- READ miss with memory: cache 3 req=1, no hits, mem_rd_ack after 5 MEM cycles -> mem_rd_addr = cache 3 address, bus_rsp[7:6]=2 one cycle after ack, grant=1000 throughout.
- RWITM with only the requester's own hit bit set: cache 1 req=2, snoop_hit=0010 -> treated as miss, MEM entered, bus_rsp[3:2]=2.
- INVALIDATE: cache 2 req=3 -> one snoop_valid with snoop_req=3, FSM back to IDLE after HIT_WAIT, all bus_rsp=0, mem_rd_req=0.
- Round-robin fairness: all four caches request READ continuously, hits forced -> grants in order 0,1,2,3,0; each cache drops its request on its response cycle; no cache is granted twice before the others.
